hazard_control_unit: RTL

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_control_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: load-use and jr stalls, jump/branch flushes, optional
// performance counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_control_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        IDEX_MemRead,
    input  logic        IDEX_RegWrite,
    input  logic [4:0]  IDEX_WriteReg,
    input  logic [4:0]  IFID_Rs,
    input  logic [4:0]  IFID_Rt,
    input  logic        IFID_UsesRt,
    input  logic        ID_Jump,
    input  logic        ID_Jr,
    input  logic        EX_BranchTaken,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXFlush,
    output logic [31:0] StallCount,
    output logic [31:0] FlushCount
);

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_JR_WAIT = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        EV_NONE     = 3'd0,
        EV_JUMP     = 3'd1,
        EV_LOAD_USE = 3'd2,
        EV_JR_HAZ   = 3'd3,
        EV_JR_WAIT  = 3'd4,
        EV_BRANCH   = 3'd5,
        EV_RESET    = 3'd6
    } event_t;

    state_t state_r;
    state_t state_nxt_s;
    event_t event_s;

    logic wr_nonzero_s;
    logic rs_match_s;
    logic rt_match_s;
    logic load_use_s;
    logic jr_haz_s;

    // Register-match decode; register 0 never creates a dependency
    always_comb begin
        wr_nonzero_s = (IDEX_WriteReg != 5'd0);
        rs_match_s   = wr_nonzero_s && (IDEX_WriteReg == IFID_Rs);
        rt_match_s   = wr_nonzero_s && IFID_UsesRt && (IDEX_WriteReg == IFID_Rt);
        load_use_s   = IDEX_MemRead && (rs_match_s || rt_match_s);
        jr_haz_s     = ID_Jr && IDEX_RegWrite && rs_match_s;
    end

    // Resolve the single winning event by priority
    always_comb begin
        event_s = EV_NONE;
        if (Reset) begin
            event_s = EV_RESET;
        end else if (EX_BranchTaken) begin
            event_s = EV_BRANCH;
        end else if (state_r == ST_JR_WAIT) begin
            event_s = EV_JR_WAIT;
        end else if (jr_haz_s) begin
            event_s = EV_JR_HAZ;
        end else if (load_use_s) begin
            event_s = EV_LOAD_USE;
        end else if (ID_Jump) begin
            event_s = EV_JUMP;
        end else begin
            event_s = EV_NONE;
        end
    end

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: only a jr behind a load needs the second stall cycle
    always_comb begin
        state_nxt_s = ST_RUN;
        case (event_s)
            EV_JR_HAZ:   state_nxt_s = IDEX_MemRead ? ST_JR_WAIT : ST_RUN;
            EV_JR_WAIT:  state_nxt_s = ST_RUN;
            EV_BRANCH:   state_nxt_s = ST_RUN;
            EV_RESET:    state_nxt_s = ST_RUN;
            default:     state_nxt_s = ST_RUN;
        endcase
    end

    // Pipeline control outputs from the winning event
    always_comb begin
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IFIDFlush = 1'b0;
        IDEXFlush = 1'b0;
        case (event_s)
            EV_BRANCH: begin
                PCWrite   = 1'b1;
                IFIDWrite = 1'b1;
                IFIDFlush = 1'b1;
                IDEXFlush = 1'b1;
            end
            EV_JR_WAIT, EV_JR_HAZ, EV_LOAD_USE: begin
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                IFIDFlush = 1'b0;
                IDEXFlush = 1'b1;
            end
            EV_JUMP: begin
                PCWrite   = 1'b1;
                IFIDWrite = 1'b1;
                IFIDFlush = 1'b1;
                IDEXFlush = 1'b0;
            end
            default: begin
                PCWrite   = 1'b1;
                IFIDWrite = 1'b1;
                IFIDFlush = 1'b0;
                IDEXFlush = 1'b0;
            end
        endcase
    end

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] stall_cnt_r;
    logic [31:0] flush_cnt_r;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic enable);
        if (enable && (value != CNT_MAX)) begin
            sat_inc = value + 32'd1;
        end else begin
            sat_inc = value;
        end
    endfunction

    // Saturating stall and flush event counters
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            stall_cnt_r <= sat_inc(stall_cnt_r, ~PCWrite);
            flush_cnt_r <= sat_inc(flush_cnt_r, EX_BranchTaken);
        end
    end

    assign StallCount = stall_cnt_r;
    assign FlushCount = flush_cnt_r;
`else
    assign StallCount = 32'd0;
    assign FlushCount = 32'd0;
`endif

endmodule
